// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and sizing helpers for serial_adder
package adder_pkg;

  // Control states of the digit-serial adder
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of DIGIT-wide slices in a WIDTH-bit operand
  function automatic int num_digits(input int width, input int digit);
    return width / digit;
  endfunction

  // Bits needed to count 0..n-1; a single-digit adder still keeps a 1-bit counter
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/digit_adder.sv
// rtl/digit_adder.sv - combinational DIGIT-bit ripple of full-adder cells
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic c;

  // Ripple the carry LSB to MSB through one full-adder cell per bit
  always_comb begin
    s = '0;
    c = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - digit-serial two's-complement adder; define SERIAL_ADDER_SUBTRACT_EN to add the sub port
module serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUBTRACT_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int N  = num_digits(WIDTH, DIGIT);
  localparam int CW = cnt_width(N);

  // Operands must split into whole digits
  if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
    $error("serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_t                  state;
  state_t                  state_nxt;
  logic [WIDTH-1:0]        a_sr;
  logic [WIDTH-1:0]        b_sr;
  logic [WIDTH-1:0]        sum_r;
  logic                    carry;
  logic                    a_msb;
  logic                    b_msb;
  logic                    cout_r;
  logic                    ovf_r;
  logic [CW-1:0]           cnt;
  logic                    last_digit;
  logic [WIDTH-1:0]        b_eff;
  logic                    c_init;
  logic [DIGIT-1:0]        dsum;
  logic                    dco;
  logic [WIDTH+DIGIT-1:0]  sum_cat;

`ifdef SERIAL_ADDER_SUBTRACT_EN
  // Subtraction is a + ~b + 1, so the carry-in is forced high and cin is ignored
  assign b_eff  = sub ? ~b : b;
  assign c_init = sub ? 1'b1 : cin;
`else
  assign b_eff  = b;
  assign c_init = cin;
`endif

  assign last_digit = (cnt == CW'(N - 1));

  // New digit enters at the top of the sum register; after N steps the LSB digit lands at bit 0
  assign sum_cat = {dsum, sum_r};

  digit_adder #(
    .DIGIT (DIGIT)
  ) u_digit_adder (
    .x  (a_sr[DIGIT-1:0]),
    .y  (b_sr[DIGIT-1:0]),
    .ci (carry),
    .s  (dsum),
    .co (dco)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; in_ready and out_valid live in disjoint states
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_digit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, per-digit shift/accumulate, and final flag capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_r  <= '0;
      carry  <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sr   <= a;
            b_sr   <= b_eff;
            sum_r  <= '0;
            carry  <= c_init;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b_eff[WIDTH-1];
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          a_sr  <= a_sr >> DIGIT;
          b_sr  <= b_sr >> DIGIT;
          sum_r <= sum_cat[WIDTH+DIGIT-1:DIGIT];
          carry <= dco;
          if (last_digit) begin
            // The last digit carries the sum MSB, so the flags are settled here
            cout_r <= dco;
            ovf_r  <= (a_msb == b_msb) && (dsum[DIGIT-1] != a_msb);
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign sum      = sum_r;
  assign cout     = cout_r;
  assign overflow = ovf_r;

endmodule
